// File: rtl/sega_joy_reader.sv
// Dual-port Sega pad scanner: drives pin-7 select, samples both DB9 ports over
// one scan frame and commits active-low {M,X,Y,Z,S,A,C,B,R,L,D,U} words atomically.
//   step | meaning
//   0,1  | select low/high, wake pads
//   2    | sample R,L,D,U,B,C with select high; clear six flag
//   3    | sample S,A (Mega Drive) or buttons 1/2 (Master System)
//   4,5  | third select low; all-zero directions mark a 6-button pad
//   6    | sample M,X,Y,Z if 6-button
//   7    | commit shadows to outputs, pulse frame_valid_o
//   8..  | idle high so 6-button pads time out
module sega_joy_reader #(
  parameter int FRAME_LEN   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        tick_i,
  input  logic [5:0]  joy1_pins_i,
  input  logic [5:0]  joy2_pins_i,
  output logic        select_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_valid_o
);

  localparam int SW = $clog2(FRAME_LEN);
  localparam logic [SW-1:0] STEP_LAST = SW'(FRAME_LEN - 1);

  logic [11:0]   sync_q [SYNC_STAGES];
  logic [5:0]    pin    [2];
  logic [SW-1:0] step;
  logic [SW-1:0] step_nxt;
  logic          select_nxt;
  logic [11:0]   shadow [2];
  logic [11:0]   joy_q  [2];
  logic [1:0]    pending_six;
  logic [1:0]    six_q;

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {joy2_pins_i, joy1_pins_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pin[0] = sync_q[SYNC_STAGES-1][5:0];
  assign pin[1] = sync_q[SYNC_STAGES-1][11:6];

  // Select is low only on even steps up to 6; everything past 7 idles high.
  always_comb begin
    step_nxt   = (step == STEP_LAST) ? '0 : step + SW'(1);
    select_nxt = !((step <= SW'(6)) && !step[0]);
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      step          <= '0;
      select_o      <= 1'b1;
      frame_valid_o <= 1'b0;
      pending_six   <= '0;
      six_q         <= '0;
      for (int p = 0; p < 2; p++) begin
        shadow[p] <= '1;
        joy_q[p]  <= '1;
      end
    end else begin
      frame_valid_o <= 1'b0;
      if (tick_i) begin
        step     <= step_nxt;
        select_o <= select_nxt;
        for (int p = 0; p < 2; p++) begin
          case (step)
            SW'(2): begin
              shadow[p][5:0] <= pin[p];
              pending_six[p] <= 1'b0;
            end
            SW'(3): begin
              if (pin[p][3:2] == 2'b00) shadow[p][7:6] <= pin[p][5:4];
              else                      shadow[p][7:4] <= {2'b11, pin[p][5:4]};
            end
            SW'(5): begin
              if (pin[p][3:0] == 4'h0) pending_six[p] <= 1'b1;
            end
            SW'(6): begin
              shadow[p][11:8] <= pending_six[p] ? pin[p][3:0] : 4'hF;
            end
            SW'(7): begin
              joy_q[p] <= shadow[p];
              six_q[p] <= pending_six[p];
            end
            default: ;
          endcase
        end
        if (step == SW'(7)) frame_valid_o <= 1'b1;
      end
    end
  end

  assign joy1_o = joy_q[0];
  assign joy2_o = joy_q[1];
  assign six1_o = six_q[0];
  assign six2_o = six_q[1];

endmodule

// File: tb/tb_sega_joy_reader.sv
// Bench for sega_joy_reader: behavioural Sega pads driven by the select line,
// expected words derived from pad type and held buttons.
module tb_sega_joy_reader;

  localparam int T_NONE = 0, T_SMS = 1, T_MD3 = 2, T_MD6 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_n, tick;
  logic [5:0]  pins1, pins2;
  logic        sel16, sel8;
  logic [11:0] j1, j2, j1_8, j2_8;
  logic        six1, six2, six1_8, six2_8;
  logic        fv16, fv8;

  sega_joy_reader #(.FRAME_LEN(16), .SYNC_STAGES(2)) u_dut (
    .clk_i(clk), .res_n_i(res_n), .tick_i(tick),
    .joy1_pins_i(pins1), .joy2_pins_i(pins2),
    .select_o(sel16), .joy1_o(j1), .joy2_o(j2),
    .six1_o(six1), .six2_o(six2), .frame_valid_o(fv16));

  sega_joy_reader #(.FRAME_LEN(8), .SYNC_STAGES(2)) u_dut8 (
    .clk_i(clk), .res_n_i(res_n), .tick_i(tick),
    .joy1_pins_i(pins1), .joy2_pins_i(pins2),
    .select_o(sel8), .joy1_o(j1_8), .joy2_o(j2_8),
    .six1_o(six1_8), .six2_o(six2_8), .frame_valid_o(fv8));

  int checks = 0;
  int errors = 0;
  int tick_n = 0;
  int fv16_cnt = 0;
  int fv16_tick = 0;
  int fv8_cnt = 0;
  int fv8_q[$];

  // Pad state: type and pressed-button mask (active-high, MXYZ SACB RLDU order).
  int          typ [2];
  logic [11:0] btn [2];
  int          n_low = 0;
  int          hi_cnt = 0;
  logic        sel_prev = 1'b1;

  // 6-button pads count select falls and forget the count after a long high period.
  always @(posedge clk) begin
    sel_prev <= sel16;
    if (sel_prev === 1'b1 && sel16 === 1'b0) n_low <= n_low + 1;
    if (sel16 === 1'b1) begin
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt > 40) n_low <= 0;
    end else begin
      hi_cnt <= 0;
    end
  end

  function automatic logic [5:0] pad_pins(int t, logic [11:0] b, logic s, int n);
    logic [11:0] a;
    a = ~b;
    case (t)
      T_SMS: return {a[5], a[4], a[3:0]};
      T_MD3: return s ? {a[5], a[4], a[3:0]} : {a[7], a[6], 2'b00, a[1:0]};
      T_MD6: begin
        if (s) return (n == 3) ? {a[5], a[4], a[11:8]} : {a[5], a[4], a[3:0]};
        else   return (n == 3) ? {a[7], a[6], 4'b0000} : {a[7], a[6], 2'b00, a[1:0]};
      end
      default: return 6'h3F;
    endcase
  endfunction

  function automatic logic [11:0] exp_word(int t, logic [11:0] b);
    case (t)
      T_SMS:   return ~(b & 12'h03F);
      T_MD3:   return ~(b & 12'h0FF);
      T_MD6:   return ~b;
      default: return 12'hFFF;
    endcase
  endfunction

  assign pins1 = pad_pins(typ[0], btn[0], sel16, n_low);
  assign pins2 = pad_pins(typ[1], btn[1], sel16, n_low);

  always @(negedge clk) begin
    if (fv16 === 1'b1) begin
      fv16_cnt++;
      fv16_tick = tick_n;
    end
    if (fv8 === 1'b1) begin
      fv8_cnt++;
      fv8_q.push_back(tick_n);
    end
  end

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    tick_n++;
    @(negedge clk);
    tick = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame();
    for (int k = 0; k < 16; k++) do_tick();
  endtask

  task automatic check_ports(string tag, int t1, logic [11:0] b1, int t2, logic [11:0] b2);
    checks++;
    if (j1 !== exp_word(t1, b1)) begin
      errors++;
      $display("FAIL %s joy1: got %h want %h", tag, j1, exp_word(t1, b1));
    end
    checks++;
    if (six1 !== (t1 == T_MD6)) begin
      errors++;
      $display("FAIL %s six1: got %b want %b", tag, six1, (t1 == T_MD6));
    end
    checks++;
    if (j2 !== exp_word(t2, b2)) begin
      errors++;
      $display("FAIL %s joy2: got %h want %h", tag, j2, exp_word(t2, b2));
    end
    checks++;
    if (six2 !== (t2 == T_MD6)) begin
      errors++;
      $display("FAIL %s six2: got %b want %b", tag, six2, (t2 == T_MD6));
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    fv16_cnt = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (sel16 !== 1'b1) begin
      errors++;
      $display("FAIL reset_select: got %b want 1", sel16);
    end
    check_ports("reset", T_NONE, 12'h000, T_NONE, 12'h000);
    checks++;
    if (fv16_cnt != 0) begin
      errors++;
      $display("FAIL reset_fv: got %0d pulses want 0", fv16_cnt);
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_md3();
    int start;
    logic exp_sel;
    typ[0] = T_MD3; btn[0] = 12'h041;
    typ[1] = T_NONE; btn[1] = 12'h000;
    fv16_cnt = 0;
    start = tick_n;
    for (int k = 0; k < 16; k++) begin
      do_tick();
      exp_sel = (k <= 6 && (k % 2) == 0) ? 1'b0 : 1'b1;
      checks++;
      if (sel16 !== exp_sel) begin
        errors++;
        $display("FAIL md3_select step %0d: got %b want %b", k, sel16, exp_sel);
      end
      checks++;
      if (fv16_cnt != ((k >= 7) ? 1 : 0)) begin
        errors++;
        $display("FAIL md3_fv_count step %0d: got %0d want %0d", k, fv16_cnt, (k >= 7) ? 1 : 0);
      end
    end
    checks++;
    if (fv16_tick != start + 8) begin
      errors++;
      $display("FAIL md3_fv_pos: got tick %0d want %0d", fv16_tick - start, 8);
    end
    checks++;
    if (j1 !== 12'hFBE) begin
      errors++;
      $display("FAIL md3_word: got %h want fbe", j1);
    end
    check_ports("md3", T_MD3, 12'h041, T_NONE, 12'h000);
  endtask

  task automatic test_md6();
    typ[0] = T_NONE; btn[0] = 12'h000;
    typ[1] = T_MD6;  btn[1] = 12'h480;
    run_frame();
    checks++;
    if (j2 !== 12'hB7F) begin
      errors++;
      $display("FAIL md6_word: got %h want b7f", j2);
    end
    check_ports("md6", T_NONE, 12'h000, T_MD6, 12'h480);
  endtask

  task automatic test_sms();
    typ[0] = T_SMS;  btn[0] = 12'h010;
    typ[1] = T_NONE; btn[1] = 12'h000;
    run_frame();
    checks++;
    if (j1 !== 12'hFEF) begin
      errors++;
      $display("FAIL sms_word: got %h want fef", j1);
    end
    check_ports("sms", T_SMS, 12'h010, T_NONE, 12'h000);
  endtask

  task automatic test_mid_reset();
    typ[0] = T_MD6; btn[0] = 12'h800;
    typ[1] = T_MD6; btn[1] = 12'h021;
    run_frame();
    check_ports("pre_reset", T_MD6, 12'h800, T_MD6, 12'h021);
    for (int k = 0; k < 5; k++) do_tick();
    @(negedge clk);
    res_n = 1'b0;
    @(negedge clk);
    checks++;
    if (sel16 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_select: got %b want 1", sel16);
    end
    check_ports("midreset", T_NONE, 12'h000, T_NONE, 12'h000);
    res_n = 1'b1;
    typ[0] = T_MD3; btn[0] = 12'h0A0;
    typ[1] = T_SMS; btn[1] = 12'h024;
    repeat (50) @(negedge clk);
    run_frame();
    check_ports("post_reset", T_MD3, 12'h0A0, T_SMS, 12'h024);
  endtask

  task automatic test_random();
    logic [11:0] b;
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 2; p++) begin
        typ[p] = int'($urandom_range(0, 3));
        b = 12'($urandom);
        if (b[0] && b[1]) b[1] = 1'b0;
        if (b[2] && b[3]) b[3] = 1'b0;
        btn[p] = b;
      end
      run_frame();
      check_ports($sformatf("random%0d", f), typ[0], btn[0], typ[1], btn[1]);
    end
  endtask

  task automatic test_wrap();
    int start;
    typ[0] = T_NONE; btn[0] = 12'h000;
    typ[1] = T_NONE; btn[1] = 12'h000;
    @(negedge clk);
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    repeat (50) @(negedge clk);
    fv8_cnt = 0;
    fv8_q.delete();
    start = tick_n;
    for (int k = 0; k < 24; k++) do_tick();
    checks++;
    if (fv8_cnt != 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 3", fv8_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= fv8_q.size()) begin
        errors++;
        $display("FAIL wrap_pos %0d: got none want tick %0d", i, 8 * (i + 1));
      end else if (fv8_q[i] - start != 8 * (i + 1)) begin
        errors++;
        $display("FAIL wrap_pos %0d: got tick %0d want %0d", i, fv8_q[i] - start, 8 * (i + 1));
      end
    end
    checks++;
    if (j1_8 !== 12'hFFF || six1_8 !== 1'b0 || j2_8 !== 12'hFFF || six2_8 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_unplugged: got %h/%b %h/%b want fff/0 fff/0", j1_8, six1_8, j2_8, six2_8);
    end
  endtask

  initial begin
    typ[0] = T_NONE; typ[1] = T_NONE;
    btn[0] = 12'h000; btn[1] = 12'h000;
    tick = 1'b0;
    res_n = 1'b0;
    test_reset();
    test_md3();
    test_md6();
    test_sms();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
